// File: rtl/exotiny_ccx_ctrl.sv
// exotiny_ccx_ctrl: sequencer for the chunked custom-instruction (CCX) port.
// It latches one CCX operation from the core and sends the operands LSB chunk
// first over the narrow CCX pins, one chunk per req/resp beat. The returned
// result chunks are reassembled into a full XLEN word.
// Optional build macro: CCX_TIMEOUT_EN adds a per-beat response timeout that
// ends the operation with err_o=1 and res_o=0.
module exotiny_ccx_ctrl #(
    parameter int XLEN      = 32,
    parameter int CHUNKSIZE = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           sel_i,
    input  logic [XLEN-1:0]      rs_a_i,
    input  logic [XLEN-1:0]      rs_b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [XLEN-1:0]      res_o,
    output logic                 err_o,
    output logic [CHUNKSIZE-1:0] ccx_rs_a_o,
    output logic [CHUNKSIZE-1:0] ccx_rs_b_o,
    input  logic [CHUNKSIZE-1:0] ccx_res_i,
    output logic [1:0]           ccx_sel_o,
    output logic                 ccx_req_o,
    input  logic                 ccx_resp_i
);

    localparam int BEATS = XLEN / CHUNKSIZE;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [XLEN-1:0] opA_q, opA_d;
    logic [XLEN-1:0] opB_q, opB_d;
    logic [XLEN-1:0] shift_q, shift_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [1:0]      sel_q, sel_d;
    logic            beatDone;

`ifdef CCX_TIMEOUT_EN
    logic [15:0]     wait_q, wait_d;
    logic            err_q, err_d;
`endif

    // A beat is accepted only while a request is actually being presented.
    assign beatDone = (state_q == XFER) && ccx_resp_i;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            shift_q <= '0;
            res_q   <= '0;
            sel_q   <= '0;
`ifdef CCX_TIMEOUT_EN
            wait_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            shift_q <= shift_d;
            res_q   <= res_d;
            sel_q   <= sel_d;
`ifdef CCX_TIMEOUT_EN
            wait_q  <= wait_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic: operands shift right one chunk per accepted beat and
    // result chunks shift in from the top, so chunk 0 ends up at the LSBs.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        shift_d = shift_q;
        res_d   = res_q;
        sel_d   = sel_q;
`ifdef CCX_TIMEOUT_EN
        wait_d  = wait_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    opA_d   = rs_a_i;
                    opB_d   = rs_b_i;
                    sel_d   = sel_i;
                    shift_d = '0;
                    beat_d  = '0;
                    state_d = XFER;
`ifdef CCX_TIMEOUT_EN
                    wait_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            XFER: begin
                if (beatDone) begin
                    shift_d = (shift_q >> CHUNKSIZE)
                            | (XLEN'(ccx_res_i) << (XLEN - CHUNKSIZE));
                    opA_d   = opA_q >> CHUNKSIZE;
                    opB_d   = opB_q >> CHUNKSIZE;
                    beat_d  = beat_q + CW'(1);
`ifdef CCX_TIMEOUT_EN
                    wait_d  = '0;
`endif
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        res_d   = shift_d;
                        state_d = DONE;
                    end
                end
`ifdef CCX_TIMEOUT_EN
                else if (wait_q == 16'(TIMEOUT)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    beat_d  = '0;
                    state_d = DONE;
                end else begin
                    wait_d  = wait_q + 16'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign res_o      = res_q;
    assign ccx_req_o  = (state_q == XFER);
    assign ccx_rs_a_o = (state_q == XFER) ? opA_q[CHUNKSIZE-1:0] : '0;
    assign ccx_rs_b_o = (state_q == XFER) ? opB_q[CHUNKSIZE-1:0] : '0;
    assign ccx_sel_o  = (state_q != IDLE) ? sel_q : 2'b00;
`ifdef CCX_TIMEOUT_EN
    assign err_o      = err_q;
`else
    assign err_o      = 1'b0;
`endif

endmodule
